drum_voice_mixer: RTL
=====================

Name: drum_voice_mixer

Overview:
- Polyphonic drum-sample mixer between the drumpad input processor (upstream) and the audio codec FIFO (downstream).
- Each one-cycle pad trigger starts or restarts playback of that pad's sample stored in memory.
- Once per output frame, the block fetches one word per active voice through the secondary port of the memory read controller, sums the words with saturation, and pushes the result into the codec FIFO.

Parameters:
- NUM_VOICES, 4, number of pads/voices; must be a power of two.
- DATA_W, 16, signed PCM sample width.
- ADDR_W, 18, memory word-address width.
- REGION_WORDS, 16384, words per voice region.
  - Voice i region base = i*REGION_WORDS.
  - Word 0 of the region is the unsigned sample length L; samples occupy words 1..L.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sample_triggers  in  NUM_VOICES  one-cycle start pulses, one bit per voice
- pause  in  1  when high, no new frame starts; a frame already in progress completes
- mem_rd_data  in  DATA_W  read data; valid only while mem_rd_valid=1
- mem_rd_valid  in  1  read data valid from read controller; may stall for any number of cycles
- mem_addr  out  ADDR_W  word address of the current request
- mem_rd_en  out  1  read request; held with a stable mem_addr until mem_rd_valid
- fifo_full  in  1  codec FIFO full
- fifo_wr_en  out  1  one-cycle FIFO write strobe
- fifo_data  out  DATA_W  mixed sample
- voices_active  out  NUM_VOICES  voice-playing flags (CPU/LED visibility)

Behaviour:
Reset values:
- All outputs 0; all voices inactive; pending triggers cleared; FSM in IDLE.
- An asserted reset mid-frame aborts the frame immediately; no FIFO write occurs.

Trigger capture:
- sample_triggers bits are OR'd into pending[] every cycle.
- pending[] is applied only on the IDLE->SCAN transition. Each pending voice gets need_hdr=1, active=1, ptr=1, and its pending bit clears.
- A trigger arriving in the same cycle as the apply is kept pending for the next frame.
- Retrigger of a playing voice restarts it from word 1.

FSM states: IDLE, SCAN, HDR, FETCH, PUSH.
- IDLE: acc=0. Go to SCAN when !fifo_full && !pause.
- SCAN: walk v = 0..NUM_VOICES-1, one voice per cycle.
  - Inactive voice: skip.
  - need_hdr: go to HDR.
  - Otherwise: go to FETCH.
  - After the last voice: go to PUSH.
- HDR: mem_rd_en=1, mem_addr=base(v). On mem_rd_valid:
  - L = mem_rd_data (unsigned) and need_hdr=0.
  - If L==0, deactivate the voice and return to SCAN with the next v.
  - Otherwise go to FETCH.
- FETCH: mem_rd_en=1, mem_addr=base(v)+ptr. On mem_rd_valid:
  - acc += sign-extended mem_rd_data.
  - ptr++.
  - If ptr==L before the increment, deactivate the voice.
  - Return to SCAN with the next v.
- PUSH: fifo_data = sat(acc), fifo_wr_en=1 for exactly one cycle, then IDLE.
  - fifo_full was checked at frame start and the codec drains at most one word per frame, so no write-while-full check is needed here.
  - If fifo_full is nonetheless high in PUSH, stay in PUSH with fifo_wr_en=0 until it deasserts.

Arithmetic:
- acc width = DATA_W+log2(NUM_VOICES), signed.
- sat() clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].

Other rules:
- No active voices: the frame still pushes 0, so silence keeps the codec fed.
- mem_rd_en deasserts in the cycle after mem_rd_valid.
- Requests are strictly one outstanding at a time.
- voices_active mirrors active[] and is registered.

Optional Feature:
- Macro MIXER_MASTER_SHIFT_EN.
- When defined:
  - Adds input port master_shift [2:0].
  - acc is arithmetic-right-shifted by master_shift before sat().
  - The port is sampled at the PUSH state.
- When undefined: the port is absent and the shift is 0.

Decomposition:
- Shared package audio_pkg:
  - FSM state enum type;
  - constants DATA_W and sample min/max;
  - function sat_sample(acc) returning the clamped DATA_W value.
- One natural sub-module: drum_voice_state, instanced per voice. It holds active, need_hdr, ptr and L, with apply/advance/load_len inputs.
- The top level holds the FSM, the accumulator and the memory/FIFO handshakes.

Test Plan:
- Single voice: memory voice0 = {L=3, 100, -200, 300}; pulse trigger[0]; rd_valid 1 cycle after request. Required: FIFO receives 100, -200, 300, then 0s; voices_active[0] falls after the third push.
- Saturation: voices 0–3 each hold L=1, sample 0x7000; trigger all four together. Required: one push of 0x7FFF. Repeat with 0x9000 samples. Required: 0x8000.
- Back-pressure and stall: hold fifo_full=1 for 50 cycles, then release; rd_valid delayed 7 cycles per request. Required: no fifo_wr_en while full; mem_addr stable during each stall; sample order is preserved.
- Retrigger: voice1 has L=10; retrigger at sample 4. Required: the next frame reads address base(1)+0 (header) and then base(1)+1.
- Reset mid-frame: assert reset_n=0 while in FETCH. Required: all outputs 0 immediately; no FIFO write; after release the FSM is IDLE and voices_active=0.
- Zero length and pause:
  - L=0 voice triggered. Required: the header is read, the voice is never active after that frame, and 0 is pushed.
  - pause=1 held. Required: no new frames start.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and helpers for the drum voice mixer: FSM state encoding,
// PCM sample limits and the saturating sample clamp.
package audio_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_HDR   = 3'd2,
    ST_FETCH = 3'd3,
    ST_PUSH  = 3'd4
  } mix_state_e;

  localparam int DATA_W     = 16;
  localparam int SAMPLE_MAX = (1 << (DATA_W - 1)) - 1;
  localparam int SAMPLE_MIN = -(1 << (DATA_W - 1));

  // Accumulators of any width up to 32 bits are sign-extended into acc.
  function automatic logic signed [DATA_W-1:0] sat_sample(input logic signed [31:0] acc);
    if (acc > SAMPLE_MAX) begin
      return DATA_W'(SAMPLE_MAX);
    end else if (acc < SAMPLE_MIN) begin
      return DATA_W'(SAMPLE_MIN);
    end
    return DATA_W'(acc);
  endfunction

endpackage

// File: rtl/drum_voice_state.sv
// Per-voice playback state: active/need_hdr flags, read pointer and sample
// length; apply restarts the voice, load_len latches the header, advance steps.
module drum_voice_state #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_apply,
  input  logic              i_advance,
  input  logic              i_load_len,
  input  logic [DATA_W-1:0] i_len,
  output logic              o_active,
  output logic              o_need_hdr,
  output logic [DATA_W-1:0] o_ptr
);
  import audio_pkg::*;

  logic              r_active;
  logic              r_need_hdr;
  logic [DATA_W-1:0] r_ptr;
  logic [DATA_W-1:0] r_len;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active   <= 1'b0;
      r_need_hdr <= 1'b0;
    end else if (i_apply) begin
      r_active   <= 1'b1;
      r_need_hdr <= 1'b1;
    end else if (i_load_len) begin
      r_need_hdr <= 1'b0;
      if (i_len == '0) begin
        r_active <= 1'b0;
      end
    end else if (i_advance && (r_ptr == r_len)) begin
      // The word just consumed was the last sample of the region.
      r_active <= 1'b0;
    end
  end

  // Pointer and length are only meaningful while active, so they carry no reset.
  always_ff @(posedge clk) begin
    if (i_apply) begin
      r_ptr <= DATA_W'(1);
    end else if (i_advance) begin
      r_ptr <= r_ptr + 1'b1;
    end
    if (i_load_len) begin
      r_len <= i_len;
    end
  end

  assign o_active   = r_active;
  assign o_need_hdr = r_need_hdr;
  assign o_ptr      = r_ptr;

endmodule

// File: rtl/drum_voice_mixer.sv
// Polyphonic drum-sample mixer: one memory word per active voice per frame,
// saturated sum pushed to the codec FIFO. Optional macro MIXER_MASTER_SHIFT_EN.
module drum_voice_mixer #(
  parameter int NUM_VOICES   = 4,
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 18,
  parameter int REGION_WORDS = 16384
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_VOICES-1:0] sample_triggers,
  input  logic                  pause,
  input  logic [DATA_W-1:0]     mem_rd_data,
  input  logic                  mem_rd_valid,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd_en,
  input  logic                  fifo_full,
  output logic                  fifo_wr_en,
  output logic [DATA_W-1:0]     fifo_data,
`ifdef MIXER_MASTER_SHIFT_EN
  input  logic [2:0]            master_shift,
`endif
  output logic [NUM_VOICES-1:0] voices_active
);
  import audio_pkg::*;

  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = DATA_W + $clog2(NUM_VOICES);
  localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

  mix_state_e               r_state;
  logic [VW-1:0]            r_v;
  logic [NUM_VOICES-1:0]    r_pending;
  logic signed [ACC_W-1:0]  r_acc;
  logic [ADDR_W-1:0]        r_mem_addr;
  logic                     r_mem_rd_en;
  logic                     r_fifo_wr_en;
  logic [DATA_W-1:0]        r_fifo_data;

  logic                     w_start;
  logic                     w_rd_done;
  logic [NUM_VOICES-1:0]    w_apply;
  logic [NUM_VOICES-1:0]    w_load_len;
  logic [NUM_VOICES-1:0]    w_advance;
  logic [NUM_VOICES-1:0]    w_active;
  logic [NUM_VOICES-1:0]    w_need_hdr;
  logic [DATA_W-1:0]        w_ptr [NUM_VOICES];
  logic [DATA_W-1:0]        w_cur_ptr;
  logic [ADDR_W-1:0]        w_base;
  logic signed [DATA_W-1:0] w_sample;
  logic [2:0]               w_shift;
  logic signed [ACC_W-1:0]  w_acc_shifted;
  logic signed [DATA_W-1:0] w_mix;

`ifdef MIXER_MASTER_SHIFT_EN
  assign w_shift = master_shift;
`else
  assign w_shift = 3'd0;
`endif

  // Holding off one cycle after a write lets fifo_full reflect that write.
  assign w_start       = (r_state == ST_IDLE) && !fifo_full && !pause && !r_fifo_wr_en;
  assign w_rd_done     = r_mem_rd_en && mem_rd_valid;
  assign w_cur_ptr     = w_ptr[r_v];
  assign w_base        = ADDR_W'(r_v) * ADDR_W'(REGION_WORDS);
  assign w_sample      = mem_rd_data;
  assign w_acc_shifted = r_acc >>> w_shift;
  assign w_mix         = sat_sample(32'(w_acc_shifted));

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    assign w_apply[gi]    = w_start && r_pending[gi];
    assign w_load_len[gi] = (r_state == ST_HDR) && w_rd_done && (r_v == VW'(gi));
    assign w_advance[gi]  = (r_state == ST_FETCH) && w_rd_done && (r_v == VW'(gi));

    drum_voice_state #(
      .DATA_W (DATA_W)
    ) u_voice (
      .clk        (clk),
      .reset_n    (reset_n),
      .i_apply    (w_apply[gi]),
      .i_advance  (w_advance[gi]),
      .i_load_len (w_load_len[gi]),
      .i_len      (mem_rd_data),
      .o_active   (w_active[gi]),
      .o_need_hdr (w_need_hdr[gi]),
      .o_ptr      (w_ptr[gi])
    );
  end

  // Triggers landing on the apply cycle survive into the next frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~w_apply) | sample_triggers;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_v          <= '0;
      r_acc        <= '0;
      r_mem_addr   <= '0;
      r_mem_rd_en  <= 1'b0;
      r_fifo_wr_en <= 1'b0;
      r_fifo_data  <= '0;
    end else begin
      r_fifo_wr_en <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_acc <= '0;
          if (w_start) begin
            r_state <= ST_SCAN;
            r_v     <= '0;
          end
        end
        ST_SCAN: begin
          if (!w_active[r_v]) begin
            if (r_v == LAST_V) begin
              r_state <= ST_PUSH;
            end else begin
              r_v <= r_v + 1'b1;
            end
          end else if (w_need_hdr[r_v]) begin
            r_state     <= ST_HDR;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= w_base;
          end else begin
            r_state     <= ST_FETCH;
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= w_base + ADDR_W'(w_cur_ptr);
          end
        end
        ST_HDR: begin
          if (w_rd_done) begin
            r_mem_rd_en <= 1'b0;
            if (mem_rd_data != '0) begin
              r_state <= ST_FETCH;
            end else if (r_v == LAST_V) begin
              r_state <= ST_PUSH;
            end else begin
              r_v     <= r_v + 1'b1;
              r_state <= ST_SCAN;
            end
          end
        end
        ST_FETCH: begin
          // Entered from HDR with no request in flight: issue the sample read.
          if (!r_mem_rd_en) begin
            r_mem_rd_en <= 1'b1;
            r_mem_addr  <= w_base + ADDR_W'(w_cur_ptr);
          end else if (mem_rd_valid) begin
            r_mem_rd_en <= 1'b0;
            r_acc       <= r_acc + ACC_W'(w_sample);
            if (r_v == LAST_V) begin
              r_state <= ST_PUSH;
            end else begin
              r_v     <= r_v + 1'b1;
              r_state <= ST_SCAN;
            end
          end
        end
        ST_PUSH: begin
          if (!fifo_full) begin
            r_fifo_wr_en <= 1'b1;
            r_fifo_data  <= w_mix;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_addr      = r_mem_addr;
  assign mem_rd_en     = r_mem_rd_en;
  assign fifo_wr_en    = r_fifo_wr_en;
  assign fifo_data     = r_fifo_data;
  assign voices_active = w_active;

endmodule
